// File: rtl/lotr_pkg.sv
// Shared LOTR ring types.
// Provides the ring opcode enum, the packed ring slot struct, the service FSM
// state enum, the bit positions of the tile ID inside an address, and a helper
// that says whether an opcode is a request that a responder must service.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;

  typedef struct packed {
    logic        valid;
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_pkt;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    RSP_WAIT = 2'd2
  } t_svc_state;

  localparam int TILE_ID_MSB = 31;
  localparam int TILE_ID_LSB = 24;

  // Only RD and WR are serviced; response opcodes on the Req ring are foreign traffic.
  function automatic logic isRequest(input t_opcode op);
    return (op == RD) || (op == WR);
  endfunction

endpackage

// File: rtl/ring_req_fifo.sv
// Synchronous FIFO of ring slots holding requests accepted by the responder.
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset (clears pointers/count)
//   push_i           - write pushData_i (honoured when not full, or full while popping)
//   pushData_i       - slot to enqueue
//   pop_i            - remove the head entry (ignored when empty)
//   popData_o        - current head entry (valid while not empty)
//   full_o, empty_o  - occupancy flags
//   count_o          - number of stored entries
module ring_req_fifo
  import lotr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  t_ring_pkt                pushData_i,
  input  logic                     pop_i,
  output t_ring_pkt                popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  t_ring_pkt        storage_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a full FIFO may still take a push alongside it.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  assign popData_o = storage_q[rdPtr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) storage_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/ring_mem_responder.sv
// Responder-only LOTR ring stop backed by a local word-addressed memory.
// Requests on the Req ring addressed to CoreID are pulled off the ring,
// queued, executed in order against the memory, and the matching
// RD_RSP/WR_RSP is injected into the first empty Rsp ring slot. All other
// traffic is forwarded with a fixed two-cycle Q500H->Q502H latency.
// Ports:
//   QClk, RstQnnnH     - clock, synchronous active-high reset
//   CoreID             - this tile's ID, compared with Address[31:24]
//   RingReqIn*Q500H    - incoming Req ring slot
//   RingRspIn*Q500H    - incoming Rsp ring slot
//   RingReqOut*Q502H   - outgoing Req ring slot
//   RingRspOut*Q502H   - outgoing Rsp ring slot
module ring_mem_responder
  import lotr_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int MEM_WORDS      = 1024,
  parameter int MEM_AW         = $clog2(MEM_WORDS)
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [7:0]  CoreID,
  input  logic        RingReqInValidQ500H,
  input  logic [9:0]  RingReqInRequestorQ500H,
  input  t_opcode     RingReqInOpcodeQ500H,
  input  logic [31:0] RingReqInAddressQ500H,
  input  logic [31:0] RingReqInDataQ500H,
  input  logic        RingRspInValidQ500H,
  input  logic [9:0]  RingRspInRequestorQ500H,
  input  t_opcode     RingRspInOpcodeQ500H,
  input  logic [31:0] RingRspInAddressQ500H,
  input  logic [31:0] RingRspInDataQ500H,
  output logic        RingReqOutValidQ502H,
  output logic [9:0]  RingReqOutRequestorQ502H,
  output t_opcode     RingReqOutOpcodeQ502H,
  output logic [31:0] RingReqOutAddressQ502H,
  output logic [31:0] RingReqOutDataQ502H,
  output logic        RingRspOutValidQ502H,
  output logic [9:0]  RingRspOutRequestorQ502H,
  output t_opcode     RingRspOutOpcodeQ502H,
  output logic [31:0] RingRspOutAddressQ502H,
  output logic [31:0] RingRspOutDataQ502H
);

  t_ring_pkt   reqIn, rspIn;
  t_ring_pkt   reqQ501_q, rspQ501_q;
  t_ring_pkt   reqQ502_q, rspQ502_q;
  t_ring_pkt   reqQ502_d, rspQ502_d;
  t_ring_pkt   fifoHead;
  t_ring_pkt   cur_q;
  t_ring_pkt   rspHold_q;
  t_svc_state  state_q;
  logic        hit, consume, inject;
  logic        fifoFull, fifoEmpty, fifoPop;
  logic [$clog2(REQ_FIFO_DEPTH):0] fifoCount;
  logic [MEM_AW-1:0] memIdx;
  logic        memWe;
  logic [31:0] mem_q [MEM_WORDS];

  assign reqIn = '{RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
                   RingReqInAddressQ500H, RingReqInDataQ500H};
  assign rspIn = '{RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
                   RingRspInAddressQ500H, RingRspInDataQ500H};

  // A hit that finds the queue full is left on the ring so it comes round again.
  assign hit     = reqQ501_q.valid
                && (reqQ501_q.address[TILE_ID_MSB:TILE_ID_LSB] == CoreID)
                && isRequest(reqQ501_q.opcode);
  assign fifoPop = (state_q == IDLE) && !fifoEmpty;
  assign consume = hit && (!fifoFull || fifoPop);

  // Occupied Rsp slots always win; the held response only takes an empty one.
  assign inject  = (state_q == RSP_WAIT) && !rspQ501_q.valid;

  assign reqQ502_d = consume ? '0 : reqQ501_q;
  assign rspQ502_d = inject ? rspHold_q : rspQ501_q;

  // Upper address bits between the index and the tile ID alias onto the same word.
  assign memIdx = cur_q.address[MEM_AW+1:2];
  assign memWe  = (state_q == EXEC) && cur_q.valid && (cur_q.opcode == WR) && !RstQnnnH;

  ring_req_fifo #(
    .DEPTH(REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i      (QClk),
    .rst_i      (RstQnnnH),
    .push_i     (consume),
    .pushData_i (reqQ501_q),
    .pop_i      (fifoPop),
    .popData_o  (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  // Both rings advance through Q501H and Q502H every cycle.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      reqQ501_q <= '0;
      rspQ501_q <= '0;
      reqQ502_q <= '0;
      rspQ502_q <= '0;
    end else begin
      reqQ501_q <= reqIn;
      rspQ501_q <= rspIn;
      reqQ502_q <= reqQ502_d;
      rspQ502_q <= rspQ502_d;
    end
  end

  // Service FSM: pop one request, execute it, then hold its response until a slot frees.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      rspHold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            cur_q   <= fifoHead;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rspHold_q.valid     <= 1'b1;
          rspHold_q.requestor <= cur_q.requestor;
          rspHold_q.address   <= cur_q.address;
          rspHold_q.opcode    <= (cur_q.opcode == WR) ? WR_RSP : RD_RSP;
          rspHold_q.data      <= (cur_q.opcode == WR) ? cur_q.data : mem_q[memIdx];
          state_q             <= RSP_WAIT;
        end
        RSP_WAIT: begin
          if (!rspQ501_q.valid) begin
            rspHold_q <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge QClk) begin
    if (memWe) mem_q[memIdx] <= cur_q.data;
  end

  assign RingReqOutValidQ502H     = reqQ502_q.valid;
  assign RingReqOutRequestorQ502H = reqQ502_q.requestor;
  assign RingReqOutOpcodeQ502H    = reqQ502_q.opcode;
  assign RingReqOutAddressQ502H   = reqQ502_q.address;
  assign RingReqOutDataQ502H      = reqQ502_q.data;
  assign RingRspOutValidQ502H     = rspQ502_q.valid;
  assign RingRspOutRequestorQ502H = rspQ502_q.requestor;
  assign RingRspOutOpcodeQ502H    = rspQ502_q.opcode;
  assign RingRspOutAddressQ502H   = rspQ502_q.address;
  assign RingRspOutDataQ502H      = rspQ502_q.data;

endmodule

// File: doc/ring_mem_responder.md
Name: ring_mem_responder

Overview:
- Responder-only ring stop and the servicing end of the ring request/response protocol that the GPC tiles initiate.
- Sits as one more tile in the LOTR ring.
- Removes requests targeted at its CoreID from the Req ring and executes them against a local word-addressed memory.
- Injects the matching RD_RSP/WR_RSP into a free Rsp ring slot.
- Forwards all other Req and Rsp traffic with the standard Q500H→Q502H two-cycle ring latency.

Parameters:
- REQ_FIFO_DEPTH, 4, depth of the accepted-request queue (power of 2, ≥2).
- MEM_WORDS, 1024, number of 32-bit words in the local memory (power of 2).
- MEM_AW, $clog2(MEM_WORDS), word-index width; the word index is Address[MEM_AW+1:2].

Ports:
- QClk  in  1  clock
- RstQnnnH  in  1  synchronous active-high reset
- CoreID  in  8  tile ID; a request targets this tile when Address[31:24]==CoreID
- RingReqInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/10/t_opcode/32/32  incoming Req slot
- RingRspInValidQ500H / RequestorQ500H / OpcodeQ500H / AddressQ500H / DataQ500H  in  1/10/t_opcode/32/32  incoming Rsp slot
- RingReqOutValidQ502H / RequestorQ502H / OpcodeQ502H / AddressQ502H / DataQ502H  out  1/10/t_opcode/32/32  outgoing Req slot
- RingRspOutValidQ502H / RequestorQ502H / OpcodeQ502H / AddressQ502H / DataQ502H  out  1/10/t_opcode/32/32  outgoing Rsp slot

Behaviour:
- Clock and reset: one clock, QClk. Reset RstQnnnH is synchronous and active-high.
- Reset values: all outputs, all pipeline valids, FIFO pointers and count, and the FSM (IDLE) are 0. Memory contents are not reset.
- Pipeline: both rings are registered at Q501H and again at Q502H. Slot latency is exactly 2 cycles, in to out.
- Req ring, at Q501H, "hit" means: valid, Address[31:24]==CoreID, and opcode is RD or WR.
  - Hit with FIFO not full: push {requestor, opcode, address, data} into the FIFO. The Q502H Req slot goes out with valid=0 and fields zeroed.
  - Hit with FIFO full: do not consume. Forward the slot unchanged, so the request recirculates and retries.
  - Non-hit, including RD_RSP/WR_RSP opcodes on the Req ring: forward unchanged.
- FIFO: a push and a pop in the same cycle are both allowed when full. A push is blocked only if full before the pop takes effect.
- Service FSM:
  - IDLE: if the FIFO is non-empty, pop and go to EXEC.
  - EXEC, one cycle:
    - WR: write Data to mem[word index]; build WR_RSP with data = written data.
    - RD: read mem[word index] (synchronous read); build RD_RSP with data = memory word.
    - In both cases requestor and address are echoed from the request. Go to RSP_WAIT.
  - RSP_WAIT: hold the response until the incoming Rsp slot at Q501H is invalid. Inject it into that slot (appears at Q502H next cycle), then go to IDLE.
- Rsp ring: an occupied slot always passes through unchanged and has priority over injection. No starvation guarantee beyond ring progress.
- Read-after-write: a RD queued behind a WR to the same word returns the new data, because service is strictly in order.
- Address wrap: only Address[MEM_AW+1:2] indexes memory. Bits between MEM_AW+2 and 23 are ignored, so indexes alias. Address[1:0] is ignored.
- Outstanding work: at most one response is held in flight (RSP_WAIT) plus REQ_FIFO_DEPTH queued requests.
- Reset mid-operation: queued requests and any held response are dropped. In-flight ring slots in Q501H/Q502H are cleared.

Decomposition:
- lotr_pkg:
  - t_opcode with RD, WR, RD_RSP, WR_RSP.
  - t_ring_pkt struct {valid, requestor[9:0], opcode, address[31:0], data[31:0]}.
  - Localparam TILE_ID_MSB=31, TILE_ID_LSB=24.
- Sub-module ring_req_fifo: parameterized synchronous FIFO of t_ring_pkt with full/empty/count.
- Memory is an inferred array inside ring_mem_responder.

Test Plan:
- Pass-through: CoreID=4, Req slot addr 0x0300_0010 RD → identical slot at Q502H 2 cycles later. Rsp out stays invalid.
- Write then read: WR addr 0x0400_0008 data 0xDEADBEEF, requestor 0x011, then RD same addr → two Req slots consumed (out valid=0).
  - WR_RSP{0x011, 0x0400_0008, 0xDEADBEEF} appears, then RD_RSP with data 0xDEADBEEF.
  - Responses are in order.
- Rsp slot contention: hold Rsp ring input fully valid for 10 cycles while a response is pending → all 10 foreign responses pass unchanged. Injection occurs in the first empty slot.
- FIFO full: block injection (Rsp ring saturated) and send 6 hits with REQ_FIFO_DEPTH=4 → 4 consumed, 1 held in EXEC/RSP_WAIT.
  - The remaining hit(s) are forwarded unchanged on Req out.
- Wrap/alias: MEM_WORDS=1024, WR addr 0x0400_1004 data 0x5 then RD 0x0400_0004 → RD_RSP data 0x5.
- Reset mid-op: assert RstQnnnH for 1 cycle with 3 queued requests → all outputs 0 next cycle, no responses ever emitted for them, and a new RD is served normally afterwards.
